// File: rtl/dual_update.sv
// ADMM dual update: y += u - z over the input block, then g += x - v over
// the state block, streaming one element per cycle through fixed-latency RAMs.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   start, active_horizon, done      run control
//   {u,z,y,x,v,g}_rdaddress/data_out read ports
//   {y,g}_wraddress/data_in/wren     dual write ports
//   prim_res_u, prim_res_x           max |u-z| and max |x-v| of last run
module dual_update #(
   parameter int STATE_DIM    = 6,
   parameter int INPUT_DIM    = 3,
   parameter int HORIZON      = 30,
   parameter int DATA_WIDTH   = 64,
   parameter int ADDR_WIDTH   = 9,
   parameter int READ_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [31:0]           active_horizon,
   output logic [ADDR_WIDTH-1:0] u_rdaddress,
   output logic [ADDR_WIDTH-1:0] z_rdaddress,
   output logic [ADDR_WIDTH-1:0] y_rdaddress,
   input  logic [DATA_WIDTH-1:0] u_data_out,
   input  logic [DATA_WIDTH-1:0] z_data_out,
   input  logic [DATA_WIDTH-1:0] y_data_out,
   output logic [ADDR_WIDTH-1:0] x_rdaddress,
   output logic [ADDR_WIDTH-1:0] v_rdaddress,
   output logic [ADDR_WIDTH-1:0] g_rdaddress,
   input  logic [DATA_WIDTH-1:0] x_data_out,
   input  logic [DATA_WIDTH-1:0] v_data_out,
   input  logic [DATA_WIDTH-1:0] g_data_out,
   output logic [ADDR_WIDTH-1:0] y_wraddress,
   output logic [DATA_WIDTH-1:0] y_data_in,
   output logic                  y_wren,
   output logic [ADDR_WIDTH-1:0] g_wraddress,
   output logic [DATA_WIDTH-1:0] g_data_in,
   output logic                  g_wren,
   output logic [DATA_WIDTH-1:0] prim_res_u,
   output logic [DATA_WIDTH-1:0] prim_res_x,
   output logic                  done
);

   localparam int RL = READ_LATENCY;
   localparam logic [31:0] HMAX = 32'(HORIZON);
   localparam logic [DATA_WIDTH-1:0] DMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
   localparam logic [DATA_WIDTH-1:0] DMAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};

   typedef enum logic [1:0] {IDLE, RUN_U, RUN_X, DONE_STATE} state_t;

   state_t state, state_nx;

   logic [31:0] h, mu, mx, m_cur, cnt;
   logic [RL-1:0] vld;
   logic [ADDR_WIDTH-1:0] pa [RL];
   logic [ADDR_WIDTH-1:0] u_addr, x_addr;
   logic in_u, in_x, accept, issue, wr, last_wr;
   logic [DATA_WIDTH-1:0] du_mag, dx_mag;

   // |d| with the most negative value pinned to the largest positive one
   function automatic logic [DATA_WIDTH-1:0] mag(input logic [DATA_WIDTH-1:0] d);
      if (!d[DATA_WIDTH-1]) return d;
      else if (d == DMIN)   return DMAX;
      else                  return -d;
   endfunction

   assign mu = (h == 32'd0) ? 32'd0 : 32'(INPUT_DIM) * (h - 32'd1);
   assign mx = 32'(STATE_DIM) * h;

   assign u_rdaddress = u_addr;
   assign z_rdaddress = u_addr;
   assign y_rdaddress = u_addr;
   assign x_rdaddress = x_addr;
   assign v_rdaddress = x_addr;
   assign g_rdaddress = x_addr;

   assign du_mag = mag(u_data_out - z_data_out);
   assign dx_mag = mag(x_data_out - v_data_out);

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // next state: a phase ends only once its last write is registered
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:       if (start) state_nx = RUN_U;
         RUN_U:      if (mu == 32'd0 || last_wr) state_nx = RUN_X;
         RUN_X:      if (mx == 32'd0 || last_wr) state_nx = DONE_STATE;
         DONE_STATE: if (!start) state_nx = IDLE;
         default:    state_nx = IDLE;
      endcase
   end

   // outputs / control
   always_comb begin
      in_u    = (state == RUN_U);
      in_x    = (state == RUN_X);
      done    = (state == DONE_STATE);
      accept  = (state == IDLE) && start;
      m_cur   = in_u ? mu : mx;
      issue   = (in_u || in_x) && (cnt < m_cur);
      wr      = vld[RL-1] && (in_u || in_x);
      last_wr = wr && (32'(pa[RL-1]) == m_cur - 32'd1);
   end

   // datapath: pa/vld carry each issued address until its data arrives
   always_ff @(posedge clk) begin
      if (rst) begin
         h           <= '0;
         cnt         <= '0;
         vld         <= '0;
         for (int i = 0; i < RL; i++) pa[i] <= '0;
         u_addr      <= '0;
         x_addr      <= '0;
         y_wraddress <= '0;
         y_data_in   <= '0;
         y_wren      <= 1'b0;
         g_wraddress <= '0;
         g_data_in   <= '0;
         g_wren      <= 1'b0;
         prim_res_u  <= '0;
         prim_res_x  <= '0;
      end else begin
         if (accept) begin
            h          <= (active_horizon > HMAX) ? HMAX : active_horizon;
            prim_res_u <= '0;
            prim_res_x <= '0;
         end

         if (state_nx != state) cnt <= '0;
         else if (issue)        cnt <= cnt + 32'd1;

         if (issue && in_u) u_addr <= cnt[ADDR_WIDTH-1:0];
         if (issue && in_x) x_addr <= cnt[ADDR_WIDTH-1:0];

         vld[0] <= issue;
         pa[0]  <= cnt[ADDR_WIDTH-1:0];
         for (int i = 1; i < RL; i++) begin
            vld[i] <= vld[i-1];
            pa[i]  <= pa[i-1];
         end

         y_wren <= wr && in_u;
         if (wr && in_u) begin
            y_wraddress <= pa[RL-1];
            y_data_in   <= y_data_out + u_data_out - z_data_out;
            if (du_mag > prim_res_u) prim_res_u <= du_mag;
         end

         g_wren <= wr && in_x;
         if (wr && in_x) begin
            g_wraddress <= pa[RL-1];
            g_data_in   <= g_data_out + x_data_out - v_data_out;
            if (dx_mag > prim_res_x) prim_res_x <= dx_mag;
         end
      end
   end

endmodule

// File: doc/dual_update.md
DUAL_UPDATE -- requirements
Module: dual_update

Interface
REQ-001 Parameters SHALL be: STATE_DIM, default 6, state dimension nx; INPUT_DIM, default 3, input dimension nu; HORIZON, default 30, maximum horizon N; DATA_WIDTH, default 64, signed two's-complement word; ADDR_WIDTH, default 9, memory address width; READ_LATENCY, default 2, cycles from registered read address to valid data.
REQ-002 Ports SHALL be (name direction width meaning):
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin one dual update
- active_horizon  in  32  horizon length for this run
- u_rdaddress / z_rdaddress / y_rdaddress  out  ADDR_WIDTH  input-side read addresses
- u_data_out / z_data_out / y_data_out  in  DATA_WIDTH  input-side read data
- x_rdaddress / v_rdaddress / g_rdaddress  out  ADDR_WIDTH  state-side read addresses
- x_data_out / v_data_out / g_data_out  in  DATA_WIDTH  state-side read data
- y_wraddress, y_data_in, y_wren  out  ADDR_WIDTH/DATA_WIDTH/1  input dual write port
- g_wraddress, g_data_in, g_wren  out  ADDR_WIDTH/DATA_WIDTH/1  state dual write port
- prim_res_u  out  DATA_WIDTH  max |u-z| of last run, unsigned
- prim_res_x  out  DATA_WIDTH  max |x-v| of last run, unsigned
- done  out  1  run complete

Function
REQ-003 The block SHALL compute y[j] = y[j] + u[j] - z[j] for j in 0..Mu-1, Mu = INPUT_DIM*(H-1), then g[j] = g[j] + x[j] - v[j] for j in 0..Mx-1, Mx = STATE_DIM*H.
REQ-004 H SHALL be active_horizon sampled at start, clamped to HORIZON when larger; H=0 gives Mu=Mx=0; H=1 gives Mu=0.
REQ-005 States SHALL be IDLE, RUN_U, RUN_X, DONE_STATE; IDLE->RUN_U on start; RUN_U->RUN_X after last U write or immediately if Mu=0; RUN_X->DONE_STATE after last X write or immediately if Mx=0.
REQ-006 Each phase SHALL issue one read address per cycle, all three read addresses of a phase equal, incrementing from 0; throughput one element per cycle.
REQ-007 Data for the address registered at edge E SHALL be sampled at edge E+READ_LATENCY; the write (wraddress = that address, data_in, wren=1) SHALL be registered on that same edge, one cycle wide per element.
REQ-008 Arithmetic SHALL be DATA_WIDTH modulo-2^DATA_WIDTH (wrap), no saturation, on the dual sum.
REQ-009 Residual difference d = u-z (or x-v) SHALL be DATA_WIDTH wrap; |d| SHALL equal 2^(DATA_WIDTH-1)-1 when d is the most negative value.
REQ-010 prim_res_u/x SHALL clear to 0 at start acceptance and update as running max during their phase; stable while done=1.
REQ-011 Exactly Mu y_wren pulses and Mx g_wren pulses SHALL occur per run; wren SHALL never assert outside RUN_U/RUN_X drain.
REQ-012 The next phase SHALL NOT issue reads until the previous phase's last write is registered.
REQ-013 done SHALL assert on entry to DONE_STATE, hold while start=1, and deassert with return to IDLE on the first cycle start=0.
REQ-014 start SHALL be ignored outside IDLE; active_horizon changes mid-run SHALL have no effect.
REQ-015 Total cycles from start accepted to done=1 SHALL NOT exceed Mu+Mx+2*READ_LATENCY+4.

Reset
REQ-016 rst=1 SHALL on the next edge force IDLE, done=0, all wren=0, all addresses and data_in=0, prim_res_u=prim_res_x=0.
REQ-017 rst mid-run SHALL abort the run with no further writes; a following start SHALL restart from index 0.

Verification
REQ-018 H=30, u=5, z=3, y=10 everywhere, x=v, g=0 -> 87 y writes of 12, 180 g writes of 0, prim_res_u=2, prim_res_x=0, done within bound.
REQ-019 H=1 -> zero y writes, 6 g writes, prim_res_u=0; H=0 -> no writes, done asserted.
REQ-020 active_horizon=40 -> treated as 30: 87 y and 180 g writes, highest addresses 86 and 179.
REQ-021 x[5]=-7, v[5]=4, other x=v -> g[5] written g[5]-11, prim_res_x=11; z=most negative, u=0 -> |d| reported 2^63-1.
REQ-022 rst asserted on 10th cycle of RUN_U -> wren low next edge, done=0; new start with H=2 -> 3 y writes at addresses 0..2, 12 g writes.
REQ-023 start held high through done -> done stays 1, no second run; start low -> done 0 next cycle, IDLE.
